// File: rtl/qrng_word_source.sv
// Von Neumann debiased entropy word source: pairs raw noise bits, packs words,
// drops warm-up words, and queues them in a FWFT FIFO with starvation/overflow flags.
module qrng_word_source #(
    parameter int WORD_W        = 64,
    parameter int FIFO_DEPTH    = 4,
    parameter int DISCARD_WORDS = 2,
    parameter int STARVE_CYCLES = 1024
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               raw_bit,
    input  logic                               raw_valid,
    output logic [WORD_W-1:0]                  entropy_data,
    output logic                               entropy_valid,
    input  logic                               entropy_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                               warm,
    output logic                               overflow,
    output logic                               starved
);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(WORD_W);
    localparam int DSC_W = $clog2(DISCARD_WORDS + 2);
    localparam int STV_W = $clog2(STARVE_CYCLES + 1);

    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(WORD_W - 1);
    localparam logic [DSC_W-1:0] DSC_TARGET = DSC_W'(DISCARD_WORDS);
    localparam logic [STV_W-1:0] STV_MAX    = STV_W'(STARVE_CYCLES);
    localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(FIFO_DEPTH);

    logic                pair_have_q, pair_have_d;
    logic                pair_bit_q,  pair_bit_d;
    logic [WORD_W-2:0]   sreg_q,      sreg_d;
    logic [CNT_W-1:0]    bit_cnt_q,   bit_cnt_d;
    logic [DSC_W-1:0]    discard_cnt_q, discard_cnt_d;
    logic                warm_q,      warm_d;
    logic                overflow_q,  overflow_d;
    logic [STV_W-1:0]    starve_cnt_q, starve_cnt_d;
    logic [PTR_W-1:0]    wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q,    rd_ptr_d;
    logic [LVL_W-1:0]    level_q,     level_d;
    logic [WORD_W-1:0]   mem_q [FIFO_DEPTH];
    logic [WORD_W-1:0]   mem_d [FIFO_DEPTH];

    logic                bit_acc;
    logic                word_done;
    logic                push;
    logic                push_ok;
    logic                pop;
    logic [WORD_W-1:0]   word;

    always_comb begin
        pair_have_d   = pair_have_q;
        pair_bit_d    = pair_bit_q;
        sreg_d        = sreg_q;
        bit_cnt_d     = bit_cnt_q;
        discard_cnt_d = discard_cnt_q;
        overflow_d    = overflow_q;
        starve_cnt_d  = starve_cnt_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        mem_d         = mem_q;
        bit_acc       = 1'b0;
        word_done     = 1'b0;
        push          = 1'b0;
        push_ok       = 1'b0;
        word          = {sreg_q, pair_bit_q};

        // A differing pair emits its first bit, which is still held in pair_bit_q.
        if (raw_valid) begin
            if (!pair_have_q) begin
                pair_have_d = 1'b1;
                pair_bit_d  = raw_bit;
            end else begin
                pair_have_d = 1'b0;
                bit_acc     = (pair_bit_q != raw_bit);
            end
        end

        if (bit_acc) begin
            sreg_d = word[WORD_W-2:0];
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d = '0;
                word_done = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end

        if (word_done) begin
            if (discard_cnt_q < DSC_TARGET) discard_cnt_d = discard_cnt_q + DSC_W'(1);
            else                            push = 1'b1;
        end
        warm_d = (discard_cnt_d == DSC_TARGET);

        pop = (level_q != '0) && entropy_ready;
        if (push) begin
            if ((level_q != LVL_FULL) || pop) begin
                mem_d[wr_ptr_q] = word;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
                push_ok         = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop);

        if (bit_acc)                    starve_cnt_d = '0;
        else if (starve_cnt_q != STV_MAX) starve_cnt_d = starve_cnt_q + STV_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pair_have_q   <= 1'b0;
            pair_bit_q    <= 1'b0;
            sreg_q        <= '0;
            bit_cnt_q     <= '0;
            discard_cnt_q <= '0;
            warm_q        <= 1'b0;
            overflow_q    <= 1'b0;
            starve_cnt_q  <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
        end else begin
            pair_have_q   <= pair_have_d;
            pair_bit_q    <= pair_bit_d;
            sreg_q        <= sreg_d;
            bit_cnt_q     <= bit_cnt_d;
            discard_cnt_q <= discard_cnt_d;
            warm_q        <= warm_d;
            overflow_q    <= overflow_d;
            starve_cnt_q  <= starve_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
        end
    end

    // Storage needs no reset: the output is gated by the level.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign entropy_valid = (level_q != '0);
    assign entropy_data  = entropy_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_level    = level_q;
    assign warm          = warm_q;
    assign overflow      = overflow_q;
    assign starved       = (starve_cnt_q == STV_MAX);

endmodule

// File: tb/tb_qrng_word_source.sv
// Randomized bench for qrng_word_source against a queue-based behavioural model
// of the debiaser, warm-up discard, FIFO and starvation monitor.
module tb_qrng_word_source;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        raw_bit = 1'b0;
    logic        raw_valid = 1'b0;
    logic        entropy_ready = 1'b0;
    logic [63:0] entropy_data;
    logic        entropy_valid;
    logic [2:0]  fifo_level;
    logic        warm;
    logic        overflow;
    logic        starved;

    int n_checks = 0;
    int n_fail   = 0;

    qrng_word_source dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .raw_bit       (raw_bit),
        .raw_valid     (raw_valid),
        .entropy_data  (entropy_data),
        .entropy_valid (entropy_valid),
        .entropy_ready (entropy_ready),
        .fifo_level    (fifo_level),
        .warm          (warm),
        .overflow      (overflow),
        .starved       (starved)
    );

    always #5 clk = ~clk;

    wire [70:0] dut_vec = {entropy_valid, entropy_data, fifo_level, warm, overflow, starved};

    // Behavioural model state
    logic        m_have;
    logic        m_first;
    logic        m_bits[$];
    logic [63:0] m_fifo[$];
    logic [63:0] m_words[$];
    int          m_disc;
    logic        m_ovf;
    int          m_starve;

    function automatic logic [70:0] exp_vec();
        logic [63:0] head;
        head = (m_fifo.size() != 0) ? m_fifo[0] : 64'd0;
        return {m_fifo.size() != 0, head, 3'(m_fifo.size()), m_disc == 2, m_ovf, m_starve == 1024};
    endfunction

    task automatic model_step(input logic rv, input logic rb, input logic rdy);
        logic        pop;
        logic        acc;
        logic        have_word;
        logic [63:0] w;
        if (!reset_n) begin
            m_have = 0; m_first = 0; m_bits.delete(); m_fifo.delete();
            m_disc = 0; m_ovf = 0; m_starve = 0;
            return;
        end
        pop = (m_fifo.size() > 0) && rdy;
        acc = 0;
        have_word = 0;
        if (rv) begin
            if (!m_have) begin
                m_have = 1; m_first = rb;
            end else begin
                m_have = 0;
                if (m_first != rb) begin
                    m_bits.push_back(m_first);
                    acc = 1;
                end
            end
        end
        if (m_bits.size() == 64) begin
            for (int i = 0; i < 64; i++) w[63-i] = m_bits[i];
            m_bits.delete();
            m_words.push_back(w);
            if (m_disc < 2) m_disc++;
            else            have_word = 1;
        end
        if (pop) void'(m_fifo.pop_front());
        if (have_word) begin
            if (m_fifo.size() < 4) m_fifo.push_back(w);
            else                   m_ovf = 1;
        end
        if (acc)                 m_starve = 0;
        else if (m_starve < 1024) m_starve++;
    endtask

    task automatic step(input logic rv, input logic rb, input logic rdy);
        raw_valid = rv; raw_bit = rb; entropy_ready = rdy;
        @(posedge clk);
        model_step(rv, rb, rdy);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic rdy);
        step(1'b1, b, rdy);
        step(1'b1, ~b, rdy);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        raw_valid = 1'b1; raw_bit = 1'b1;
        do_reset();
        n_checks++;
        if (dut_vec !== 71'd0) begin
            n_fail++; $display("FAIL reset_outputs got=%h exp=0", dut_vec);
        end
        n_checks++;
        if (dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL reset_model got=%h exp=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_pairs();
        logic [9:0] seq;
        seq = 10'b01_10_00_11_10;
        for (int i = 9; i >= 0; i--) step(1'b1, seq[i], 1'b0);
        n_checks++;
        if (dut.bit_cnt_q !== 6'd3) begin
            n_fail++; $display("FAIL pairs_bit_cnt got=%0d exp=3", dut.bit_cnt_q);
        end
        n_checks++;
        if (dut.sreg_q[2:0] !== 3'b011) begin
            n_fail++; $display("FAIL pairs_sreg got=%b exp=011", dut.sreg_q[2:0]);
        end
        n_checks++;
        if (entropy_valid !== 1'b0 || fifo_level !== 3'd0) begin
            n_fail++; $display("FAIL pairs_no_word valid=%b level=%0d exp 0/0", entropy_valid, fifo_level);
        end
    endtask

    task automatic test_warmup();
        do_reset();
        for (int i = 0; i < 127; i++) send_bit(1'b1, 1'b0);
        n_checks++;
        if (warm !== 1'b0) begin
            n_fail++; $display("FAIL warm_early got=%b exp=0", warm);
        end
        send_bit(1'b1, 1'b0);
        n_checks++;
        if (warm !== 1'b1 || fifo_level !== 3'd0) begin
            n_fail++; $display("FAIL warm_rise warm=%b level=%0d exp 1/0", warm, fifo_level);
        end
        for (int i = 0; i < 64; i++) send_bit(1'b1, 1'b0);
        n_checks++;
        if (fifo_level !== 3'd1 || entropy_data !== 64'hFFFF_FFFF_FFFF_FFFF || entropy_valid !== 1'b1) begin
            n_fail++; $display("FAIL warm_word level=%0d data=%h valid=%b exp 1/ffffffffffffffff/1",
                               fifo_level, entropy_data, entropy_valid);
        end
    endtask

    task automatic test_pattern();
        step(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (entropy_valid !== 1'b0 || entropy_data !== 64'd0) begin
            n_fail++; $display("FAIL pop_empty valid=%b data=%h exp 0/0", entropy_valid, entropy_data);
        end
        for (int i = 0; i < 31; i++) begin
            send_bit(1'b1, 1'b0);
            send_bit(1'b0, 1'b0);
        end
        send_bit(1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (entropy_valid !== 1'b0) begin
            n_fail++; $display("FAIL pattern_pre valid=%b exp=0", entropy_valid);
        end
        step(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (entropy_valid !== 1'b1 || entropy_data !== 64'hAAAA_AAAA_AAAA_AAAA) begin
            n_fail++; $display("FAIL pattern_word valid=%b data=%h exp 1/aaaaaaaaaaaaaaaa", entropy_valid, entropy_data);
        end
    endtask

    task automatic test_overflow();
        logic b;
        step(1'b0, 1'b0, 1'b1);
        m_words.delete();
        for (int i = 0; i < 5 * 64; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        n_checks++;
        if (fifo_level !== 3'd4 || overflow !== 1'b1 || entropy_data !== m_words[0]) begin
            n_fail++; $display("FAIL ovf_full level=%0d ovf=%b head=%h exp 4/1/%h",
                               fifo_level, overflow, entropy_data, m_words[0]);
        end
        for (int i = 0; i < 63; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        b = 1'($urandom_range(0, 1));
        step(1'b1, b, 1'b0);
        step(1'b1, ~b, 1'b1);
        n_checks++;
        if (fifo_level !== 3'd4 || overflow !== 1'b1 || entropy_data !== m_words[1]) begin
            n_fail++; $display("FAIL ovf_push_pop level=%0d ovf=%b head=%h exp 4/1/%h",
                               fifo_level, overflow, entropy_data, m_words[1]);
        end
        n_checks++;
        if (dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL ovf_model got=%h exp=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_starve();
        do_reset();
        for (int i = 0; i < 1023; i++) step(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (starved !== 1'b0) begin
            n_fail++; $display("FAIL starve_1023 got=%b exp=0", starved);
        end
        step(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (starved !== 1'b1) begin
            n_fail++; $display("FAIL starve_1024 got=%b exp=1", starved);
        end
        step(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (starved !== 1'b1) begin
            n_fail++; $display("FAIL starve_half_pair got=%b exp=1", starved);
        end
        step(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (starved !== 1'b0) begin
            n_fail++; $display("FAIL starve_clear got=%b exp=0", starved);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4 * 64; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        n_checks++;
        if (fifo_level !== 3'd2) begin
            n_fail++; $display("FAIL mid_queued got=%0d exp=2", fifo_level);
        end
        for (int i = 0; i < 30; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        do_reset();
        n_checks++;
        if (dut_vec !== 71'd0) begin
            n_fail++; $display("FAIL mid_reset got=%h exp=0", dut_vec);
        end
        for (int i = 0; i < 2 * 64; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        n_checks++;
        if (fifo_level !== 3'd0 || warm !== 1'b1) begin
            n_fail++; $display("FAIL mid_rediscard level=%0d warm=%b exp 0/1", fifo_level, warm);
        end
        for (int i = 0; i < 64; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        n_checks++;
        if (fifo_level !== 3'd1 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL mid_after got=%h exp=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        logic rv, rb, rdy;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rv  = ($urandom_range(0, 3) != 0);
            rb  = 1'($urandom_range(0, 1));
            rdy = ($urandom_range(0, 5) == 0);
            step(rv, rb, rdy);
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        m_have = 0; m_first = 0; m_disc = 0; m_ovf = 0; m_starve = 0;
        #2;
        test_reset();
        test_pairs();
        test_warmup();
        test_pattern();
        test_overflow();
        test_starve();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
